// File: rtl/fp8_pkg.sv
// fp8 mini-float adder shared types.
// Format: [7:5] exponent, [4:0] mantissa, no hidden bit.
package fp8_pkg;

  localparam int EXP_W = 3;
  localparam int MAN_W = 5;
  localparam int W     = EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    ADD,
    DONE
  } state_t;

  function automatic logic [EXP_W-1:0] exp_of(
    input logic [W-1:0] x
  );
    return x[W-1:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] man_of(
    input logic [W-1:0] x
  );
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/big_number_first.sv
// Comparator-swap: puts the larger mini-float first.
// Ties on exponent go to mantissa; full ties keep A first.
module big_number_first
  import fp8_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] big,
  output logic [W-1:0] sml
);

  logic aFirst;

  // order by exponent, then mantissa
  always_comb begin
    aFirst = (exp_of(a) > exp_of(b)) ||
             ((exp_of(a) == exp_of(b)) &&
              (man_of(a) >= man_of(b)));
    big = aFirst ? a : b;
    sml = aFirst ? b : a;
  end

endmodule

// File: rtl/fp8_add_sequencer.sv
// Multi-cycle fp8 adder: order, align one bit
// per cycle, add, normalise or saturate.
module fp8_add_sequencer
  import fp8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  state_t state;
  state_t nextState;

  logic [W-1:0]     aReg;
  logic [W-1:0]     bReg;
  logic [W-1:0]     bigOp;
  logic [W-1:0]     smlOp;
  logic [EXP_W-1:0] eBig;
  logic [MAN_W-1:0] mBig;
  logic [MAN_W-1:0] mSml;
  logic [EXP_W-1:0] cnt;
  logic [MAN_W:0]   sum;

  big_number_first uOrder (
    .a   (aReg),
    .b   (bReg),
    .big (bigOp),
    .sml (smlOp)
  );

  assign sum   = {1'b0, mBig} + {1'b0, mSml};
  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // next-state decode
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = LOAD;
      LOAD:    nextState = ALIGN;
      ALIGN:   if (cnt == '0) nextState = ADD;
      ADD:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // capture, align, add and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg   <= '0;
      bReg   <= '0;
      eBig   <= '0;
      mBig   <= '0;
      mSml   <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            aReg <= a_in;
            bReg <= b_in;
          end
        end
        LOAD: begin
          eBig <= exp_of(bigOp);
          mBig <= man_of(bigOp);
          mSml <= man_of(smlOp);
          cnt  <= exp_of(bigOp) - exp_of(smlOp);
        end
        ALIGN: begin
          if (cnt != '0) begin
            mSml <= mSml >> 1;
            cnt  <= cnt - 1'b1;
          end
        end
        ADD: begin
          done <= 1'b1;
          if (!sum[MAN_W]) begin
            result <= {eBig, sum[MAN_W-1:0]};
            ovf    <= 1'b0;
          end else if (eBig != EXP_MAX) begin
            result <= {eBig + 1'b1, sum[MAN_W:1]};
            ovf    <= 1'b0;
          end else begin
            result <= '1;
            ovf    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Bench for fp8_add_sequencer: vector table,
// hand sequences and random ops vs a value model.
module tb_fp8_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] aIn = 8'h00;
  logic [7:0] bIn = 8'h00;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       ovf;

  int nCompared = 0;
  int nMismatch = 0;

  fp8_add_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (aIn),
    .b_in   (bIn),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name,
                       input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // value-level model: order, align by division,
  // add, then normalise or saturate
  task automatic refModel(input logic [7:0] a,
                          input logic [7:0] b,
                          output logic [7:0] res,
                          output logic o,
                          output int lat);
    int eA, mA, eB, mB, eBg, mBg, eSm, mSm;
    int diff, s;
    eA = int'(a[7:5]); mA = int'(a[4:0]);
    eB = int'(b[7:5]); mB = int'(b[4:0]);
    if (eA > eB || (eA == eB && mA >= mB)) begin
      eBg = eA; mBg = mA; eSm = eB; mSm = mB;
    end else begin
      eBg = eB; mBg = mB; eSm = eA; mSm = mA;
    end
    diff = eBg - eSm;
    s = mBg + mSm / (1 << diff);
    o = 1'b0;
    if (s < 32)
      res = 8'(eBg * 32 + s);
    else if (eBg < 7)
      res = 8'((eBg + 1) * 32 + s / 2);
    else begin
      res = 8'hFF;
      o = 1'b1;
    end
    lat = diff + 3;
  endtask

  // one operation; lat counts edges after accept
  task automatic runOp(input logic [7:0] a,
                       input logic [7:0] b,
                       input int injectAt,
                       output logic [7:0] res,
                       output logic o,
                       output int lat,
                       output logic single);
    lat = -1;
    res = 8'h00;
    o = 1'b0;
    single = 1'b0;
    @(negedge clk);
    start = 1'b1;
    aIn = a;
    bIn = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    aIn = 8'($urandom);
    bIn = 8'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == injectAt) begin
        start = 1'b1;
        aIn = 8'h21;
        bIn = 8'h21;
      end
      if (done) begin
        lat = n;
        res = result;
        o = ovf;
        break;
      end
    end
    start = 1'b0;
    if (lat > 0) begin
      @(posedge clk);
      #1;
      single = !done;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, mr;
    logic o, mo, sg;
    int lt, mlt;

    vecs[0] = '{8'h21, 8'h21, 8'h22, 1'b0, 3};
    vecs[1] = '{8'h70, 8'h28, 8'h72, 1'b0, 5};
    vecs[2] = '{8'h28, 8'h70, 8'h72, 1'b0, 5};
    vecs[3] = '{8'h54, 8'h54, 8'h74, 1'b0, 3};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 3};
    vecs[5] = '{8'h01, 8'h00, 8'h01, 1'b0, 3};
    vecs[6] = '{8'hE1, 8'h01, 8'hE1, 1'b0, 10};

    #7;
    check("rst ready", int'(ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst result", int'(result), 0);
    check("rst ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", int'(ready), 1);

    foreach (vecs[i]) begin
      runOp(vecs[i].a, vecs[i].b, 0, r, o, lt, sg);
      check($sformatf("vec%0d result", i),
            int'(r), int'(vecs[i].res));
      check($sformatf("vec%0d ovf", i),
            int'(o), int'(vecs[i].ovf));
      check($sformatf("vec%0d latency", i),
            lt, vecs[i].lat);
      check($sformatf("vec%0d pulse", i),
            int'(sg), 1);
    end

    runOp(8'hE1, 8'h01, 4, r, o, lt, sg);
    check("ignored start result", int'(r), 8'hE1);
    check("ignored start latency", lt, 10);
    @(negedge clk);
    check("ignored start idle", int'(ready), 1);
    check("ignored start held", int'(result), 8'hE1);

    @(negedge clk);
    start = 1'b1;
    aIn = 8'hE1;
    bIn = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort busy before", int'(busy), 1);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort ready", int'(ready), 1);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    check("abort ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp(8'h21, 8'h21, 0, r, o, lt, sg);
    check("post abort result", int'(r), 8'h22);
    check("post abort latency", lt, 3);
    check("post abort pulse", int'(sg), 1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      refModel(ra, rb, mr, mo, mlt);
      runOp(ra, rb, 0, r, o, lt, sg);
      check($sformatf("rand %h+%h result", ra, rb),
            int'(r), int'(mr));
      check($sformatf("rand %h+%h ovf", ra, rb),
            int'(o), int'(mo));
      check($sformatf("rand %h+%h latency", ra, rb),
            lt, mlt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatch);
    $finish;
  end

endmodule
